hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 tb/tb_hazard_scoreboard.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Fetch/decode hazard scoreboard: per-register countdown timers, counted control shadow, NOP injection.
// Optional build macro FORWARDING_EN: only loads arm a register timer, with LOAD_USE_DELAY cycles.
module hazard_scoreboard #(
   parameter int          NUM_REGS       = 8,
   parameter int          REG_IDX_W      = 3,
   parameter int          WB_LATENCY     = 3,
   parameter int          LOAD_USE_DELAY = 1,
   parameter int          CTRL_SHADOW    = 4,
   parameter int          STAT_W         = 16,
   parameter logic [15:0] NOP_INST       = 16'h0800
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          fetch_inst,
   input  logic                 inst_valid,
   input  logic [REG_IDX_W-1:0] src1_idx,
   input  logic                 src1_used,
   input  logic [REG_IDX_W-1:0] src2_idx,
   input  logic                 src2_used,
   input  logic [REG_IDX_W-1:0] dst_idx,
   input  logic                 dst_wr,
   input  logic                 is_load,
   input  logic                 is_ctrl,
   input  logic                 ctrl_resolve,
   output logic [15:0]          next_inst,
   output logic                 pc_stall,
   output logic                 issue,
   output logic [NUM_REGS-1:0]  busy_vec,
   output logic [STAT_W-1:0]    stall_cnt
);

   localparam int TMAX = (WB_LATENCY > LOAD_USE_DELAY) ? WB_LATENCY : LOAD_USE_DELAY;
   localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
   localparam int SW   = (CTRL_SHADOW > 0) ? $clog2(CTRL_SHADOW + 1) : 1;

   logic [TW-1:0]     timer_q [NUM_REGS];
   logic [TW-1:0]     timer_d [NUM_REGS];
   logic [SW-1:0]     shadow_q, shadow_d;
   logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic          data_haz, ctrl_haz;
   logic          load_en;
   logic [TW-1:0] load_val;

   assign data_haz = (src1_used && (timer_q[src1_idx] != '0)) ||
                     (src2_used && (timer_q[src2_idx] != '0));
   assign ctrl_haz = (shadow_q != '0);

   assign issue     = inst_valid && !rst && !data_haz && !ctrl_haz;
   assign pc_stall  = inst_valid && !rst && (data_haz || ctrl_haz);
   assign next_inst = issue ? fetch_inst : NOP_INST;
   assign stall_cnt = stall_cnt_q;

`ifdef FORWARDING_EN
   // ALU results are bypassed; only load results need a use delay.
   assign load_en  = issue && dst_wr && is_load;
   assign load_val = TW'(LOAD_USE_DELAY);
`else
   assign load_en  = issue && dst_wr;
   assign load_val = TW'(WB_LATENCY);
`endif

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_vec[r] = (timer_q[r] != '0);
         timer_d[r]  = timer_q[r];
         if (load_en && (dst_idx == REG_IDX_W'(r))) begin
            timer_d[r] = load_val;
         end else if (timer_q[r] != '0) begin
            timer_d[r] = timer_q[r] - TW'(1);
         end
      end
   end

   // A new control issue wins over an early resolve in the same cycle.
   always_comb begin
      shadow_d = shadow_q;
      if (issue && is_ctrl) begin
         shadow_d = SW'(CTRL_SHADOW);
      end else if (ctrl_resolve) begin
         shadow_d = '0;
      end else if (shadow_q != '0) begin
         shadow_d = shadow_q - SW'(1);
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (pc_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            timer_q[r] <= '0;
         end
         shadow_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            timer_q[r] <= timer_d[r];
         end
         shadow_q    <= shadow_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; a second instance with STAT_W=2 checks saturation.
module tb_hazard_scoreboard;

   localparam logic [15:0] NOP = 16'h0800;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] fetch_inst;
   logic        inst_valid;
   logic [2:0]  src1_idx, src2_idx, dst_idx;
   logic        src1_used, src2_used, dst_wr, is_load, is_ctrl, ctrl_resolve;

   logic [15:0] next_inst, s_next_inst;
   logic        pc_stall, issue, s_pc_stall, s_issue;
   logic [7:0]  busy_vec, s_busy_vec;
   logic [15:0] stall_cnt;
   logic [1:0]  s_stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk(clk), .rst(rst), .fetch_inst(fetch_inst), .inst_valid(inst_valid),
      .src1_idx(src1_idx), .src1_used(src1_used), .src2_idx(src2_idx), .src2_used(src2_used),
      .dst_idx(dst_idx), .dst_wr(dst_wr), .is_load(is_load), .is_ctrl(is_ctrl),
      .ctrl_resolve(ctrl_resolve), .next_inst(next_inst), .pc_stall(pc_stall),
      .issue(issue), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
   );

   hazard_scoreboard #(.STAT_W(2)) dut_small (
      .clk(clk), .rst(rst), .fetch_inst(fetch_inst), .inst_valid(inst_valid),
      .src1_idx(src1_idx), .src1_used(src1_used), .src2_idx(src2_idx), .src2_used(src2_used),
      .dst_idx(dst_idx), .dst_wr(dst_wr), .is_load(is_load), .is_ctrl(is_ctrl),
      .ctrl_resolve(ctrl_resolve), .next_inst(s_next_inst), .pc_stall(s_pc_stall),
      .issue(s_issue), .busy_vec(s_busy_vec), .stall_cnt(s_stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      inst_valid   = 1'b0;
      fetch_inst   = 16'h0000;
      src1_idx     = 3'd0;
      src1_used    = 1'b0;
      src2_idx     = 3'd0;
      src2_used    = 1'b0;
      dst_idx      = 3'd0;
      dst_wr       = 1'b0;
      is_load      = 1'b0;
      is_ctrl      = 1'b0;
      ctrl_resolve = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst        = 1'b1;
      inst_valid = 1'b1;
      fetch_inst = 16'h1111;
      #2;
      chk("rst_issue", 32'(issue), 32'd0);
      chk("rst_pc_stall", 32'(pc_stall), 32'd0);
      chk("rst_next_inst", 32'(next_inst), 32'(NOP));
      tick();
      tick();
      rst = 1'b0;
      idle();
      #1;
      chk("post_rst_busy", 32'(busy_vec), 32'd0);
      chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("idle_next_inst", 32'(next_inst), 32'(NOP));
      chk("idle_pc_stall", 32'(pc_stall), 32'd0);
      tick();

`ifndef FORWARDING_EN
      // ADD R1 at t, SUB reading R1 from t+1: stalls t+1..t+3, issues t+4
      inst_valid = 1'b1; fetch_inst = 16'h2101; dst_idx = 3'd1; dst_wr = 1'b1;
      #1;
      chk("add_issue", 32'(issue), 32'd1);
      chk("add_next_inst", 32'(next_inst), 32'h2101);
      tick();
      idle();
      inst_valid = 1'b1; fetch_inst = 16'h3211; src1_idx = 3'd1; src1_used = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         #1;
         chk("raw_pc_stall", 32'(pc_stall), 32'd1);
         chk("raw_issue", 32'(issue), 32'd0);
         chk("raw_next_inst", 32'(next_inst), 32'(NOP));
         if (k == 1) chk("raw_busy", 32'(busy_vec), 32'h02);
         tick();
      end
      #1;
      chk("raw_release_issue", 32'(issue), 32'd1);
      chk("raw_release_inst", 32'(next_inst), 32'h3211);
      chk("raw_stall_cnt", 32'(stall_cnt), 32'd3);
      chk("raw_small_cnt", 32'(s_stall_cnt), 32'd3);
      tick();
`endif

      rst = 1'b1; idle();
      tick();
      rst = 1'b0;

      // BEQZ at t, independent instruction held: stalls t+1..t+4, issues t+5
      inst_valid = 1'b1; fetch_inst = 16'h4000; is_ctrl = 1'b1;
      #1;
      chk("beqz_issue", 32'(issue), 32'd1);
      tick();
      idle();
      inst_valid = 1'b1; fetch_inst = 16'h5555;
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk("shadow_pc_stall", 32'(pc_stall), 32'd1);
         chk("shadow_next_inst", 32'(next_inst), 32'(NOP));
         chk("small_cnt_ramp", 32'(s_stall_cnt), 32'(k - 1));
         tick();
      end
      #1;
      chk("shadow_release_issue", 32'(issue), 32'd1);
      chk("shadow_stall_cnt", 32'(stall_cnt), 32'd4);
      chk("small_cnt_sat", 32'(s_stall_cnt), 32'd3);
      tick();

      // BEQZ at t, resolve at t+2: issue at t+3
      idle();
      inst_valid = 1'b1; fetch_inst = 16'h4001; is_ctrl = 1'b1;
      #1;
      chk("beqz2_issue", 32'(issue), 32'd1);
      tick();
      idle();
      inst_valid = 1'b1; fetch_inst = 16'h5556;
      #1;
      chk("resolve_t1_stall", 32'(pc_stall), 32'd1);
      tick();
      ctrl_resolve = 1'b1;
      #1;
      chk("resolve_t2_stall", 32'(pc_stall), 32'd1);
      tick();
      ctrl_resolve = 1'b0;
      #1;
      chk("resolve_t3_issue", 32'(issue), 32'd1);
      chk("resolve_stall_cnt", 32'(stall_cnt), 32'd6);
      chk("small_cnt_hold", 32'(s_stall_cnt), 32'd3);
      tick();

`ifndef FORWARDING_EN
      // Writes to R2 at t and t+1, reader at t+2: issue at t+5
      idle();
      inst_valid = 1'b1; fetch_inst = 16'h6002; dst_idx = 3'd2; dst_wr = 1'b1;
      #1;
      chk("w2a_issue", 32'(issue), 32'd1);
      tick();
      #1;
      chk("w2b_issue", 32'(issue), 32'd1);
      chk("w2b_busy", 32'(busy_vec), 32'h04);
      tick();
      idle();
      inst_valid = 1'b1; fetch_inst = 16'h7020; src2_idx = 3'd2; src2_used = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("waw_pc_stall", 32'(pc_stall), 32'd1);
         tick();
      end
      #1;
      chk("waw_issue", 32'(issue), 32'd1);
      chk("waw_busy_clear", 32'(busy_vec), 32'd0);
      tick();

      // ADDI R5,R5 at t issues; dependent stalls at t+1; rst at t+2
      idle();
      inst_valid = 1'b1; fetch_inst = 16'h8555;
      src1_idx = 3'd5; src1_used = 1'b1; dst_idx = 3'd5; dst_wr = 1'b1;
      #1;
      chk("self_dep_issue", 32'(issue), 32'd1);
      tick();
      #1;
      chk("self_dep_stall", 32'(pc_stall), 32'd1);
      chk("self_dep_busy", 32'(busy_vec), 32'h20);
      tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_next_inst", 32'(next_inst), 32'(NOP));
      chk("mid_rst_issue", 32'(issue), 32'd0);
      chk("mid_rst_pc_stall", 32'(pc_stall), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("after_rst_busy", 32'(busy_vec), 32'd0);
      chk("after_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("after_rst_issue", 32'(issue), 32'd1);
      tick();

      // JAL R7 sets both its timer and the shadow
      idle();
      inst_valid = 1'b1; fetch_inst = 16'h9007; is_ctrl = 1'b1; dst_idx = 3'd7; dst_wr = 1'b1;
      #1;
      chk("jal_issue", 32'(issue), 32'd1);
      tick();
      idle();
      inst_valid = 1'b1; fetch_inst = 16'h5557;
      #1;
      chk("jal_busy", 32'(busy_vec), 32'hA0);
      chk("jal_shadow_stall", 32'(pc_stall), 32'd1);
      tick();
`else
      rst = 1'b1; idle();
      tick();
      rst = 1'b0;
      // ADD R3 then reader: bypassed, no stall
      inst_valid = 1'b1; fetch_inst = 16'h2303; dst_idx = 3'd3; dst_wr = 1'b1;
      #1;
      chk("fwd_add_issue", 32'(issue), 32'd1);
      tick();
      idle();
      inst_valid = 1'b1; fetch_inst = 16'h3330; src1_idx = 3'd3; src1_used = 1'b1;
      #1;
      chk("fwd_reader_issue", 32'(issue), 32'd1);
      chk("fwd_busy", 32'(busy_vec), 32'd0);
      tick();
      // LD R4 then reader: exactly one stall
      idle();
      inst_valid = 1'b1; fetch_inst = 16'hA404; dst_idx = 3'd4; dst_wr = 1'b1; is_load = 1'b1;
      #1;
      chk("fwd_ld_issue", 32'(issue), 32'd1);
      tick();
      idle();
      inst_valid = 1'b1; fetch_inst = 16'h3440; src2_idx = 3'd4; src2_used = 1'b1;
      #1;
      chk("fwd_lu_stall", 32'(pc_stall), 32'd1);
      chk("fwd_lu_busy", 32'(busy_vec), 32'h10);
      tick();
      #1;
      chk("fwd_lu_issue", 32'(issue), 32'd1);
      chk("fwd_lu_stall_cnt", 32'(stall_cnt), 32'd1);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
